// File: rtl/ifetch_unit.sv
// Fetch stage: holds the PC, issues one word-aligned imem request at a time and
// registers the returned instruction for the decoder, honouring redirects and stalls.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic        drop;
  logic [31:0] target;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;
  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC & 32'hFFFF_FFFC;
      pc_inflight <= RESET_PC & 32'hFFFF_FFFC;
      drop        <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= NOP_INST;
      inst_pc     <= 32'h0000_0000;
    end else begin
      if (redirect_valid) pc <= target;
      case (state)
        REQ: begin
          if (imem_gnt) begin
            pc_inflight <= pc;
            // a redirect in the grant cycle means this fetch used the old path
            drop        <= redirect_valid;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= REQ;
            if (!drop && !redirect_valid) begin
              inst       <= imem_rdata;
              inst_pc    <= pc_inflight;
              inst_valid <= 1'b1;
              pc         <= pc_inflight + 32'd4;
              state      <= HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            state      <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios with literal checks, then randomized
// memory timing, redirects, stalls and resets against a transaction-level model.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  ifetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: next fetch address, one outstanding fetch (maybe dead), held instruction
  bit          m_known = 0;
  logic [31:0] m_pc = 32'h0, m_fly = 32'h0, m_inst = 32'h0, m_ipc = 32'h0;
  bit          m_busy = 0, m_dead = 0, m_hv = 0;

  // Memory responder
  bit          p_pend = 0;
  int          p_cnt = 0;
  logic [31:0] p_addr = 32'h0;
  int          gnt_pct = 100, lat_min = 0, lat_max = 0, spur_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0010: return 32'hDEAD_BEEF;
      default:       return a * 32'h9E37_79B1 + 32'h0123_4567;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model and memory.
  task automatic tick(input bit r, input bit rv, input logic [31:0] rpc, input bit st);
    logic [31:0] e_inst, tgt;
    bit          e_req, deliver;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    deliver        = p_pend && (p_cnt == 0);
    imem_rvalid    = deliver;
    if (!p_pend && ($urandom_range(99) < spur_pct)) imem_rvalid = 1'b1;
    imem_rdata     = deliver ? mem_word(p_addr) : $urandom;
    imem_gnt       = !p_pend && ($urandom_range(99) < gnt_pct);
    #1;
    if (m_known) begin
      e_req  = !r && !m_busy && !m_hv;
      e_inst = m_hv ? m_inst : NOP;
      chk("imem_req",   {31'b0, imem_req},   {31'b0, e_req});
      chk("imem_addr",  imem_addr,           m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hv});
      chk("inst",       inst,                e_inst);
      chk("inst_pc",    inst_pc,             m_ipc);
      chk("opcode",     {25'b0, opcode},     {25'b0, e_inst[6:0]});
      chk("funct3",     {29'b0, funct3},     {29'b0, e_inst[14:12]});
    end
    tgt = rpc & 32'hFFFF_FFFC;
    if (r) begin
      m_known = 1; m_pc = 32'h0; m_busy = 0; m_dead = 0; m_hv = 0; m_ipc = 32'h0;
    end else if (!m_busy && !m_hv) begin
      if (imem_gnt) begin m_busy = 1; m_fly = m_pc; m_dead = rv; end
      if (rv) m_pc = tgt;
    end else if (m_busy) begin
      if (imem_rvalid) begin
        m_busy = 0;
        if (!m_dead && !rv) begin
          m_hv = 1; m_inst = imem_rdata; m_ipc = m_fly; m_pc = m_fly + 32'd4;
        end
        m_dead = 0;
      end else if (rv) m_dead = 1;
      if (rv) m_pc = tgt;
    end else begin
      if (rv) begin m_hv = 0; m_pc = tgt; end
      else if (!st) m_hv = 0;
    end
    if (deliver) p_pend = 0;
    else if (p_pend) p_cnt--;
    if (imem_req && imem_gnt) begin
      p_pend = 1; p_addr = imem_addr; p_cnt = $urandom_range(lat_max, lat_min);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] rpc;
    @(negedge clk);

    // Reset then steady fetch
    tick(1, 0, 0, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, NOP);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("f0_inst", inst, 32'h0050_0093);
    chk("f0_opcode", {25'b0, opcode}, 32'h13);
    chk("f0_funct3", {29'b0, funct3}, 32'h0);
    chk("f0_pc", inst_pc, 32'h0);
    tick(0, 0, 0, 0);
    chk("f0_next_addr", imem_addr, 32'h4);

    // Stall hold at pc 8
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("stall_pc", inst_pc, 32'h8);
    held = inst;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1);
      chk("stall_valid", {31'b0, inst_valid}, 32'h1);
      chk("stall_inst", inst, held);
      chk("stall_ipc", inst_pc, 32'h8);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
    end
    tick(0, 0, 0, 0);
    chk("stall_next_addr", imem_addr, 32'hC);

    // Redirect in WAIT, response one cycle later
    repeat (3) tick(0, 0, 0, 0);
    chk("w_addr10", imem_addr, 32'h10);
    lat_min = 1; lat_max = 1;
    tick(0, 0, 0, 0);
    tick(0, 1, 32'h40, 0);
    tick(0, 0, 0, 0);
    chk("w_valid", {31'b0, inst_valid}, 32'h0);
    chk("w_addr40", imem_addr, 32'h40);
    lat_min = 0; lat_max = 0;

    // Redirect coincident with grant, then with rvalid
    tick(0, 1, 32'h43, 0);
    tick(0, 0, 0, 0);
    chk("cg_valid", {31'b0, inst_valid}, 32'h0);
    chk("cg_addr", imem_addr, 32'h40);
    tick(0, 0, 0, 0);
    tick(0, 1, 32'h43, 0);
    chk("cr_valid", {31'b0, inst_valid}, 32'h0);
    chk("cr_addr", imem_addr, 32'h40);

    // Wrap-around
    tick(0, 1, 32'hFFFF_FFFC, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while waiting; late response after reset is ignored
    lat_min = 1; lat_max = 1;
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("lr_addr", imem_addr, 32'h0);
    chk("lr_valid", {31'b0, inst_valid}, 32'h0);
    chk("lr_inst", inst, NOP);

    // Randomized traffic
    gnt_pct = 60; lat_min = 0; lat_max = 3; spur_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 + $urandom_range(15);
      else rpc = $urandom & 32'h0000_FFFF;
      tick(($urandom_range(99) < 1), ($urandom_range(99) < 8), rpc, ($urandom_range(99) < 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch stage directly upstream of the control decoder.
- Holds the PC and issues one word-aligned request at a time to instruction memory over a req/gnt/rvalid handshake.
- Registers the returned instruction and presents it, with its opcode and funct3 fields, to the decoder and datapath.
- Accepts a branch/jump redirect from the execute stage and discards any in-flight fetch on the wrong path.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] must be 0).
- NOP_INST, 32'h00000013, instruction presented while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  byte address of request; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts request this cycle (meaningful only when imem_req=1).
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  take redirect this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- stall  in  1  downstream not accepting; held instruction must not advance.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst  out  32  held instruction, or NOP_INST when inst_valid=0.
- inst_pc  out  32  PC of held instruction.
- opcode  out  7  inst[6:0], combinational from inst.
- funct3  out  3  inst[14:12], combinational from inst.

Behaviour:
- Reset, while rst=1 and in the cycle after:
  - pc=RESET_PC, state=REQ, drop=0, inst_valid=0, inst=NOP_INST, inst_pc=0.
  - imem_req=0 while rst=1.
- States: REQ, WAIT, HOLD. At most one request outstanding.
- REQ:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT; latch pc_inflight=pc.
  - Otherwise stay in REQ.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: inst<=imem_rdata, inst_pc<=pc_inflight, inst_valid<=1, pc<=pc_inflight+4, go to HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop, go to REQ; pc is unchanged (already the redirect target).
- HOLD:
  - inst_valid=1, imem_req=0.
  - stall=0: instruction consumed this cycle; inst_valid<=0, inst<=NOP_INST, go to REQ.
  - stall=1: hold all outputs stable.
- imem_rvalid outside WAIT is ignored.
- Redirect (redirect_valid=1) has priority over stall and the normal transitions. pc <= {redirect_pc[31:2],2'b00}.
  - In REQ without gnt: go to REQ. imem_addr shows the new pc next cycle. An ungranted request address may change.
  - In REQ with gnt the same cycle: the granted fetch used the old address. Set drop=1, go to WAIT.
  - In WAIT without rvalid: set drop=1, stay in WAIT.
  - In WAIT with rvalid the same cycle: discard the data, drop<=0, go to REQ.
  - In HOLD: inst_valid<=0, inst<=NOP_INST, go to REQ; the held instruction is killed.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000.
- Latency:
  - REQ with immediate gnt, then rvalid on the next cycle: inst_valid rises 2 cycles after the REQ cycle.
  - Peak throughput is one instruction per 3 cycles.
- rst asserted in any state, including WAIT or HOLD, returns to the reset values. A late imem_rvalid arriving in the cycle after reset (state REQ) is ignored.
- opcode and funct3 always track inst. Decoder inputs therefore see NOP fields (opcode 7'b0010011, funct3 3'b000) when invalid.

Test Plan:
- Reset then steady fetch: rst 1 cycle, gnt always 1, rvalid 1 cycle after gnt, mem[0]=32'h00500093, stall=0 -> imem_addr=0; inst=32'h00500093, opcode=7'h13, funct3=0, inst_pc=0; next imem_addr=4.
- Stall hold: inst valid at pc 8, stall=1 for 5 cycles -> inst, inst_pc=8, inst_valid constant, imem_req=0; stall=0 -> next imem_addr=12.
- Redirect in WAIT: gnt on addr 0x10, redirect_pc=0x40 the next cycle, rvalid (data 0xDEADBEEF) the cycle after -> data discarded, inst_valid stays 0, next imem_addr=0x40.
- Redirect coincident with gnt and with rvalid: both the old-address response is dropped and no instruction is emitted for it; redirect_pc=0x43 -> imem_addr=0x40.
- Wrap-around: redirect to 0xFFFFFFFC, fetch completes and is consumed -> following imem_addr=0x00000000.
- Reset mid-operation: rst in WAIT, then rvalid arrives in the cycle after rst drops -> ignored; imem_addr=RESET_PC; inst_valid=0, inst=NOP_INST.
